// File: rtl/alu_issue_if.sv
// Handshake bundle around the issue stage: instruction channel from upstream and
// request/acknowledge channel to alu_fsm. The master side is the issue stage itself.
interface alu_issue_if #(
    parameter int PA_DATA  = 32,
    parameter int PA_FNCT  = 9,
    parameter int PA_RADDR = 3
);
    logic                ins_valid;
    logic                ins_ready;
    logic [PA_FNCT-1:0]  ins_fnct;
    logic [PA_RADDR-1:0] ins_rd;
    logic [PA_RADDR-1:0] ins_ra;
    logic [PA_RADDR-1:0] ins_rb;

    logic                alu_req;
    logic [PA_DATA-1:0]  alu_a;
    logic [PA_DATA-1:0]  alu_b;
    logic [PA_FNCT-1:0]  alu_fnct;
    logic [PA_DATA-1:0]  alu_res;
    logic                alu_ack;
    logic                alu_zf;
    logic                alu_nf;

    modport master (
        input  ins_valid, ins_fnct, ins_rd, ins_ra, ins_rb,
        output ins_ready,
        output alu_req, alu_a, alu_b, alu_fnct,
        input  alu_res, alu_ack, alu_zf, alu_nf
    );

    modport slave (
        output ins_valid, ins_fnct, ins_rd, ins_ra, ins_rb,
        input  ins_ready,
        input  alu_req, alu_a, alu_b, alu_fnct,
        output alu_res, alu_ack, alu_zf, alu_nf
    );
endinterface

// File: rtl/alu_issue.sv
// Issue/writeback stage in front of alu_fsm: operand fetch from a small register file,
// request/ack sequencing with a watchdog, result writeback and sticky CHK flags.
module alu_issue #(
    parameter int PA_DATA    = 32,
    parameter int PA_FNCT    = 9,
    parameter int PA_RADDR   = 3,
    parameter int PA_TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst_b,
    alu_issue_if.master         bus,
    input  logic                i_ld_en,
    input  logic [PA_RADDR-1:0] i_ld_addr,
    input  logic [PA_DATA-1:0]  i_ld_data,
    input  logic [PA_RADDR-1:0] i_dbg_addr,
    output logic [PA_DATA-1:0]  o_dbg_data,
    output logic                o_done,
    output logic                o_done_err,
    output logic                o_flag_z,
    output logic                o_flag_n
);
    localparam int NREG = 2 ** PA_RADDR;
    localparam int WD_W = (PA_TIMEOUT > 1) ? $clog2(PA_TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(PA_TIMEOUT - 1);

    localparam logic [PA_FNCT-1:0] FN_ADD = PA_FNCT'(32'h040);
    localparam logic [PA_FNCT-1:0] FN_SUB = PA_FNCT'(32'h041);
    localparam logic [PA_FNCT-1:0] FN_AND = PA_FNCT'(32'h080);
    localparam logic [PA_FNCT-1:0] FN_SFR = PA_FNCT'(32'h084);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_FIN} state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic                r_alu_req;
    logic [PA_DATA-1:0]  r_alu_a;
    logic [PA_DATA-1:0]  r_alu_b;
    logic [PA_FNCT-1:0]  r_alu_fnct;
    logic [PA_RADDR-1:0] r_rd;
    logic [WD_W-1:0]     r_wd;
    logic                r_done;
    logic                r_done_err;
    logic                r_flag_z;
    logic                r_flag_n;

    logic [PA_DATA-1:0]  r_rf [NREG];

    logic                w_legal;
    logic                w_is_chk;
    logic                w_wd_expired;
    logic                w_accept;
    logic                w_ack_wait;
    logic                w_wb_en;
    logic                w_flag_en;
    logic                w_req_next;
    logic                w_done_next;
    logic                w_err_next;

    // alu_fsm never acks codes outside this set, so they are rejected before a request
    assign w_legal = (bus.ins_fnct[PA_FNCT-1:6] == '0)
                  || (bus.ins_fnct == FN_ADD) || (bus.ins_fnct == FN_SUB)
                  || ((bus.ins_fnct >= FN_AND) && (bus.ins_fnct <= FN_SFR));
    assign w_is_chk     = (r_alu_fnct[PA_FNCT-1:6] == '0);
    assign w_wd_expired = (r_wd == WD_MAX);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state    <= S_IDLE;
            r_alu_req  <= 1'b0;
            r_done     <= 1'b0;
            r_done_err <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_alu_req  <= w_req_next;
            r_done     <= w_done_next;
            r_done_err <= w_err_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.ins_valid) w_state_next = w_legal ? S_REQ : S_FIN;
            S_REQ:   w_state_next = S_WAIT;
            S_WAIT:  if (bus.alu_ack || w_wd_expired) w_state_next = S_FIN;
            S_FIN:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // An ack in the last watchdog cycle still counts as a normal completion
    always_comb begin
        w_accept    = (r_state == S_IDLE) && bus.ins_valid;
        w_ack_wait  = (r_state == S_WAIT) && bus.alu_ack;
        w_wb_en     = w_ack_wait && !w_is_chk;
        w_flag_en   = w_ack_wait && w_is_chk;
        w_req_next  = (w_state_next == S_REQ);
        w_done_next = (w_state_next == S_FIN);
        w_err_next  = (w_accept && !w_legal)
                   || ((r_state == S_WAIT) && !bus.alu_ack && w_wd_expired);
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_fnct <= '0;
            r_rd       <= '0;
            r_wd       <= '0;
            r_flag_z   <= 1'b0;
            r_flag_n   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_alu_a    <= r_rf[bus.ins_ra];
                r_alu_b    <= r_rf[bus.ins_rb];
                r_alu_fnct <= bus.ins_fnct;
                r_rd       <= bus.ins_rd;
            end
            if (r_state == S_REQ) begin
                r_wd <= '0;
            end else if (r_state == S_WAIT) begin
                r_wd <= r_wd + WD_W'(1);
            end
            if (w_flag_en) begin
                r_flag_z <= bus.alu_zf;
                r_flag_n <= bus.alu_nf;
            end
        end
    end

    // No reset on the storage; the later assignment gives writeback priority over ld
    always_ff @(posedge clk) begin
        if (i_ld_en) begin
            r_rf[i_ld_addr] <= i_ld_data;
        end
        if (w_wb_en) begin
            r_rf[r_rd] <= bus.alu_res;
        end
    end

    assign bus.ins_ready = (r_state == S_IDLE) && rst_b;
    assign bus.alu_req   = r_alu_req;
    assign bus.alu_a     = r_alu_a;
    assign bus.alu_b     = r_alu_b;
    assign bus.alu_fnct  = r_alu_fnct;
    assign o_dbg_data    = r_rf[i_dbg_addr];
    assign o_done        = r_done;
    assign o_done_err    = r_done_err;
    assign o_flag_z      = r_flag_z;
    assign o_flag_n      = r_flag_n;
endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a behavioural alu_fsm responder
// (11-cycle add/sub, 3-cycle others, optional never-ack and injected stray acks).
module tb_alu_issue;
    logic        clk = 1'b0;
    logic        rst_b;
    logic        i_ld_en;
    logic [2:0]  i_ld_addr;
    logic [31:0] i_ld_data;
    logic [2:0]  i_dbg_addr;
    logic [31:0] o_dbg_data;
    logic        o_done, o_done_err, o_flag_z, o_flag_n;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int req_cnt = 0, done_cnt = 0, req_cyc = 0, done_cyc = 0;
    logic last_err = 1'b0;
    int acc_cyc = 0, d0 = 0, r0 = 0;

    logic        never_ack = 1'b0;
    logic        inj_ack   = 1'b0;
    logic [31:0] inj_res   = 32'h0;
    logic        m_busy    = 1'b0;
    int          m_cnt     = 0;
    logic [31:0] m_res     = 32'h0;
    logic [31:0] rv;

    alu_issue_if #(.PA_DATA(32), .PA_FNCT(9), .PA_RADDR(3)) bus ();

    alu_issue #(.PA_DATA(32), .PA_FNCT(9), .PA_RADDR(3), .PA_TIMEOUT(16)) dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .bus        (bus),
        .i_ld_en    (i_ld_en),
        .i_ld_addr  (i_ld_addr),
        .i_ld_data  (i_ld_data),
        .i_dbg_addr (i_dbg_addr),
        .o_dbg_data (o_dbg_data),
        .o_done     (o_done),
        .o_done_err (o_done_err),
        .o_flag_z   (o_flag_z),
        .o_flag_n   (o_flag_n)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_b === 1'b1) begin
            if (bus.alu_req === 1'b1) begin
                req_cnt++;
                req_cyc = cyc;
            end
            if (o_done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
                last_err = o_done_err;
            end
        end
    end

    // Behavioural alu_fsm: flags follow the result; CHK passes operand A through
    always @(posedge clk) begin
        #1;
        bus.alu_ack = inj_ack;
        bus.alu_res = inj_res;
        bus.alu_zf  = 1'b0;
        bus.alu_nf  = 1'b0;
        if (rst_b !== 1'b1) begin
            m_busy      = 1'b0;
            bus.alu_ack = 1'b0;
        end else begin
            if (m_busy) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_busy      = 1'b0;
                    bus.alu_ack = 1'b1;
                    bus.alu_res = m_res;
                    bus.alu_zf  = (m_res == 32'h0);
                    bus.alu_nf  = m_res[31];
                end
            end
            if (bus.alu_req === 1'b1 && !never_ack) begin
                m_busy = 1'b1;
                m_cnt  = (bus.alu_fnct[8:6] == 3'b001) ? 11 : 3;
                case (bus.alu_fnct)
                    9'h040:  m_res = bus.alu_a + bus.alu_b;
                    9'h041:  m_res = bus.alu_a - bus.alu_b;
                    9'h080:  m_res = bus.alu_a & bus.alu_b;
                    9'h081:  m_res = bus.alu_a | bus.alu_b;
                    9'h082:  m_res = bus.alu_a ^ bus.alu_b;
                    9'h083:  m_res = bus.alu_a << bus.alu_b[4:0];
                    9'h084:  m_res = bus.alu_a >> bus.alu_b[4:0];
                    default: m_res = bus.alu_a;
                endcase
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd_rf(input logic [2:0] addr, output logic [31:0] data);
        i_dbg_addr = addr;
        #1;
        data = o_dbg_data;
    endtask

    task automatic ld(input logic [2:0] addr, input logic [31:0] data);
        @(negedge clk);
        i_ld_en   = 1'b1;
        i_ld_addr = addr;
        i_ld_data = data;
        @(negedge clk);
        i_ld_en   = 1'b0;
        $display("load r%0d=%h", addr, data);
    endtask

    task automatic issue(input logic [8:0] fn, input logic [2:0] rd, input logic [2:0] ra,
                         input logic [2:0] rb);
        int n = 0;
        @(negedge clk);
        while (bus.ins_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", {31'h0, bus.ins_ready}, 32'h1);
        acc_cyc = cyc;
        d0 = done_cnt;
        r0 = req_cnt;
        bus.ins_fnct  = fn;
        bus.ins_rd    = rd;
        bus.ins_ra    = ra;
        bus.ins_rb    = rb;
        bus.ins_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.ins_valid = 1'b0;
    endtask

    task automatic wait_done(input string what);
        int n = 0;
        while (done_cnt == d0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        chk("done_seen", done_cnt - d0, 32'h1);
        $display("%s: req_cyc=%0d done_cyc=%0d err=%b", what, req_cyc, done_cyc, last_err);
    endtask

    initial begin
        rst_b = 1'b0;
        bus.ins_valid = 1'b0;
        bus.ins_fnct  = '0;
        bus.ins_rd    = '0;
        bus.ins_ra    = '0;
        bus.ins_rb    = '0;
        i_ld_en    = 1'b0;
        i_ld_addr  = '0;
        i_ld_data  = '0;
        i_dbg_addr = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'h0, bus.ins_ready}, 32'h0);
        chk("rst_req", {31'h0, bus.alu_req}, 32'h0);
        chk("rst_a", bus.alu_a, 32'h0);
        chk("rst_b", bus.alu_b, 32'h0);
        chk("rst_fnct", {23'h0, bus.alu_fnct}, 32'h0);
        chk("rst_done", {30'h0, o_done, o_done_err}, 32'h0);
        chk("rst_flags", {30'h0, o_flag_z, o_flag_n}, 32'h0);
        @(negedge clk);
        rst_b = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_rst", {31'h0, bus.ins_ready}, 32'h1);

        ld(3'd1, 32'd3);
        ld(3'd2, 32'd5);
        issue(9'h040, 3'd3, 3'd1, 3'd2);
        wait_done("add");
        chk("add_req_pulses", req_cnt - r0, 32'd1);
        chk("add_lat", done_cyc - req_cyc, 32'd12);
        chk("add_req_cycle", req_cyc - acc_cyc, 32'd1);
        chk("add_err", {31'h0, last_err}, 32'h0);
        rd_rf(3'd3, rv);
        chk("add_r3", rv, 32'd8);

        ld(3'd1, 32'd5);
        ld(3'd2, 32'd7);
        issue(9'h041, 3'd4, 3'd1, 3'd2);
        wait_done("sub");
        rd_rf(3'd4, rv);
        chk("sub_r4", rv, 32'hFFFF_FFFE);
        chk("sub_lat", done_cyc - req_cyc, 32'd12);
        issue(9'h082, 3'd5, 3'd1, 3'd2);
        wait_done("xor");
        rd_rf(3'd5, rv);
        chk("xor_r5", rv, 32'h0000_0002);
        chk("xor_lat", done_cyc - req_cyc, 32'd4);

        ld(3'd7, 32'h0000_1234);
        ld(3'd6, 32'h8000_0000);
        issue(9'h000, 3'd7, 3'd6, 3'd0);
        wait_done("chk_neg");
        chk("chk1_flags", {30'h0, o_flag_z, o_flag_n}, 32'h1);
        chk("chk1_err", {31'h0, last_err}, 32'h0);
        rd_rf(3'd7, rv);
        chk("chk1_r7", rv, 32'h0000_1234);
        ld(3'd6, 32'h0);
        issue(9'h000, 3'd7, 3'd6, 3'd0);
        wait_done("chk_zero");
        chk("chk2_flags", {30'h0, o_flag_z, o_flag_n}, 32'h2);
        rd_rf(3'd7, rv);
        chk("chk2_r7", rv, 32'h0000_1234);

        issue(9'h042, 3'd3, 3'd1, 3'd2);
        wait_done("illegal");
        chk("ill_no_req", req_cnt - r0, 32'd0);
        chk("ill_done_cycle", done_cyc - acc_cyc, 32'd1);
        chk("ill_err", {31'h0, last_err}, 32'h1);
        rd_rf(3'd3, rv);
        chk("ill_r3", rv, 32'd8);
        issue(9'h081, 3'd5, 3'd1, 3'd2);
        wait_done("or_after_illegal");
        chk("or_err", {31'h0, last_err}, 32'h0);
        rd_rf(3'd5, rv);
        chk("or_r5", rv, 32'd7);

        never_ack = 1'b1;
        issue(9'h040, 3'd4, 3'd1, 3'd2);
        wait_done("timeout");
        chk("to_err", {31'h0, last_err}, 32'h1);
        chk("to_lat", done_cyc - req_cyc, 32'd17);
        chk("to_req_pulses", req_cnt - r0, 32'd1);
        rd_rf(3'd4, rv);
        chk("to_r4", rv, 32'hFFFF_FFFE);
        never_ack = 1'b0;
        d0 = done_cnt;
        @(negedge clk);
        inj_res = 32'h0000_DEAD;
        inj_ack = 1'b1;
        @(negedge clk);
        inj_ack = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("late_ack_no_done", done_cnt - d0, 32'd0);
        rd_rf(3'd4, rv);
        chk("late_ack_r4", rv, 32'hFFFF_FFFE);
        chk("late_ack_ready", {31'h0, bus.ins_ready}, 32'h1);

        issue(9'h040, 3'd3, 3'd1, 3'd2);
        begin
            int n = 0;
            while (bus.alu_ack !== 1'b1 && n < 40) begin
                @(posedge clk);
                #2;
                n++;
            end
        end
        chk("coll_ack_seen", {31'h0, bus.alu_ack}, 32'h1);
        i_ld_en   = 1'b1;
        i_ld_addr = 3'd3;
        i_ld_data = 32'h0000_0BAD;
        @(posedge clk);
        #1;
        i_ld_en = 1'b0;
        wait_done("collision");
        rd_rf(3'd3, rv);
        chk("coll_r3", rv, 32'd12);

        issue(9'h040, 3'd5, 3'd1, 3'd2);
        repeat (4) @(posedge clk);
        #1;
        chk("wait_a_frozen", bus.alu_a, 32'd5);
        chk("wait_fnct_frozen", {23'h0, bus.alu_fnct}, 32'h40);
        @(negedge clk);
        rst_b = 1'b0;
        #1;
        chk("mid_rst_req", {31'h0, bus.alu_req}, 32'h0);
        chk("mid_rst_ab", bus.alu_a | bus.alu_b, 32'h0);
        chk("mid_rst_fnct", {23'h0, bus.alu_fnct}, 32'h0);
        chk("mid_rst_done", {30'h0, o_done, o_done_err}, 32'h0);
        chk("mid_rst_flags", {30'h0, o_flag_z, o_flag_n}, 32'h0);
        chk("mid_rst_ready", {31'h0, bus.ins_ready}, 32'h0);
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("mid_rst_no_done", done_cnt - d0, 32'd0);
        rd_rf(3'd5, rv);
        chk("mid_rst_r5", rv, 32'd7);
        chk("mid_rst_ready_after", {31'h0, bus.ins_ready}, 32'h1);
        $display("reset during WAIT: done_cnt=%0d", done_cnt);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
